// File: rtl/bloom_filter_pkg.sv
// ---------------------------------------------------------------------------
// bloom_filter_pkg
//   Shared types and constants for the Bloom-filter match path.
//   - Geometry localparams (string size range, hashes per size, position width)
//   - match_rec_t : one queued match record {pos, size, mask}
//   - longest_size(): highest set mask bit converted to a string size
// ---------------------------------------------------------------------------
package bloom_filter_pkg;

    localparam int MAX_STR_SIZE  = 20;
    localparam int MIN_STR_SIZE  = 8;
    localparam int HASHES_CNT    = 6;
    localparam int POS_W         = 16;
    localparam int STR_SIZES_CNT = MAX_STR_SIZE - MIN_STR_SIZE + 1;
    localparam int STR_SIZE_W    = $clog2(MAX_STR_SIZE + 1);

    typedef struct packed {
        logic [POS_W-1:0]         pos;
        logic [STR_SIZE_W-1:0]    size;
        logic [STR_SIZES_CNT-1:0] mask;
    } match_rec_t;

    // Highest set index plus MIN_STR_SIZE; 0 when no bit is set.
    function automatic logic [STR_SIZE_W-1:0] longest_size(
        input logic [STR_SIZES_CNT-1:0] mask
    );
        logic [STR_SIZE_W-1:0] size;
        size = '0;
        for (int i = 0; i < STR_SIZES_CNT; i++) begin
            if (mask[i]) begin
                size = STR_SIZE_W'(i + MIN_STR_SIZE);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/match_fifo.sv
// ---------------------------------------------------------------------------
// match_fifo
//   Show-ahead synchronous FIFO of match_rec_t records.
//   Ports:
//     clk_i, rst_i : clock, asynchronous active-high reset
//     flush_i      : synchronous pointer reset (contents become invalid)
//     push_i/data_i: write one record (caller guarantees !full or a same-cycle pop)
//     pop_i        : drop the head record (caller guarantees !empty)
//     data_o       : head record, valid whenever empty_o = 0
//     full_o/empty_o
// ---------------------------------------------------------------------------
module match_fifo
    import bloom_filter_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  match_rec_t data_i,
    input  logic       pop_i,
    output match_rec_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    match_rec_t  mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset; validity comes from the pointers, and the top masks the head while empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/bloom_match_collector.sv
// ---------------------------------------------------------------------------
// bloom_match_collector
//   Aligns each hash lookup with its returning LUT read data, ANDs the
//   per-size hash bits into a Bloom hit mask, and queues {pos, longest size,
//   mask} records in a show-ahead FIFO for a ready/valid consumer.
//   Ports:
//     clk_i, rst_i        : clock, asynchronous active-high reset
//     config_i            : LUT reconfiguration; discards in-flight lookups,
//                           flushes the FIFO, blocks pushes/pops/counting
//     hash_valid_i/pos_i  : lookup issued to the LUT this cycle
//     lut_rd_data_i       : [MAX..MIN][HASHES_CNT-1:0] membership bits
//     match_*             : FIFO head (valid/ready handshake)
//     cnt_clr_i           : synchronous clear of both counters
//     hit_cnt_o/drop_cnt_o: saturating hit and FIFO-overflow counters
//   Record geometry is taken from bloom_filter_pkg; the size parameters below
//   must keep their package defaults.
// ---------------------------------------------------------------------------
module bloom_match_collector #(
    parameter int MAX_STR_SIZE   = bloom_filter_pkg::MAX_STR_SIZE,
    parameter int MIN_STR_SIZE   = bloom_filter_pkg::MIN_STR_SIZE,
    parameter int HASHES_CNT     = bloom_filter_pkg::HASHES_CNT,
    parameter int LUT_RD_LATENCY = 1,
    parameter int POS_W          = bloom_filter_pkg::POS_W,
    parameter int FIFO_DEPTH     = 16,
    parameter int CNT_W          = 32
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_i,
    input  logic                                                    config_i,
    input  logic                                                    hash_valid_i,
    input  logic [POS_W-1:0]                                        hash_pos_i,
    input  logic [(MAX_STR_SIZE-MIN_STR_SIZE+1)*HASHES_CNT-1:0]     lut_rd_data_i,
    output logic                                                    match_valid_o,
    input  logic                                                    match_ready_i,
    output logic [POS_W-1:0]                                        match_pos_o,
    output logic [$clog2(MAX_STR_SIZE+1)-1:0]                       match_size_o,
    output logic [MAX_STR_SIZE-MIN_STR_SIZE:0]                      match_mask_o,
    input  logic                                                    cnt_clr_i,
    output logic [CNT_W-1:0]                                        hit_cnt_o,
    output logic [CNT_W-1:0]                                        drop_cnt_o
);

    import bloom_filter_pkg::match_rec_t;
    import bloom_filter_pkg::longest_size;

    localparam int SIZES = MAX_STR_SIZE - MIN_STR_SIZE + 1;
    localparam int LAT   = LUT_RD_LATENCY;

    // ---------------- delay line ----------------
    logic [LAT-1:0]            dl_vld_q;
    logic [LAT-1:0][POS_W-1:0] dl_pos_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_vld_q <= '0;
            dl_pos_q <= '0;
        end else begin
            // Lookups issued or in flight during config are discarded.
            dl_vld_q[0] <= hash_valid_i & ~config_i;
            dl_pos_q[0] <= hash_pos_i;
            for (int i = 1; i < LAT; i++) begin
                dl_vld_q[i] <= dl_vld_q[i-1] & ~config_i;
                dl_pos_q[i] <= dl_pos_q[i-1];
            end
        end
    end

    logic             aligned;
    logic [POS_W-1:0] aligned_pos;
    assign aligned     = dl_vld_q[LAT-1];
    assign aligned_pos = dl_pos_q[LAT-1];

    // ---------------- hit detection ----------------
    logic [SIZES-1:0] hit_mask;
    logic             hit;

    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < SIZES; i++) begin
            hit_mask[i] = &lut_rd_data_i[i*HASHES_CNT +: HASHES_CNT];
        end
    end

    assign hit = |hit_mask;

    // ---------------- FIFO control ----------------
    logic       push_try, push, pop, drop;
    logic       fifo_full, fifo_empty;
    match_rec_t rec_in, rec_head;

    assign push_try = aligned & hit & ~config_i;
    assign pop      = ~fifo_empty & match_ready_i & ~config_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = push_try & (~fifo_full | pop);
    assign drop     = push_try & ~push;

    always_comb begin
        rec_in      = '0;
        rec_in.pos  = aligned_pos;
        rec_in.mask = hit_mask;
        rec_in.size = longest_size(hit_mask);
    end

    match_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (config_i),
        .push_i  (push),
        .data_i  (rec_in),
        .pop_i   (pop),
        .data_o  (rec_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head fields read as zero while nothing is queued.
    assign match_valid_o = ~fifo_empty;
    assign match_pos_o   = fifo_empty ? '0 : rec_head.pos;
    assign match_size_o  = fifo_empty ? '0 : rec_head.size;
    assign match_mask_o  = fifo_empty ? '0 : rec_head.mask;

    // ---------------- saturating counters ----------------
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (cnt_clr_i) begin
            hit_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (push_try && !(&hit_cnt_q))  hit_cnt_d  = hit_cnt_q + 1'b1;
            if (drop && !(&drop_cnt_q))     drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bloom_match_collector.sv
// ---------------------------------------------------------------------------
// tb_bloom_match_collector
//   Directed bench for bloom_match_collector with default parameters
//   (LUT_RD_LATENCY = 1, FIFO_DEPTH = 16). Inputs change 1 time unit after
//   the rising edge; outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_bloom_match_collector;

    localparam int LUT_W = 13 * 6;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             config_i;
    logic             hash_valid_i;
    logic [15:0]      hash_pos_i;
    logic [LUT_W-1:0] lut_rd_data_i;
    logic             match_valid_o;
    logic             match_ready_i;
    logic [15:0]      match_pos_o;
    logic [4:0]       match_size_o;
    logic [12:0]      match_mask_o;
    logic             cnt_clr_i;
    logic [31:0]      hit_cnt_o;
    logic [31:0]      drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    bloom_match_collector dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .config_i      (config_i),
        .hash_valid_i  (hash_valid_i),
        .hash_pos_i    (hash_pos_i),
        .lut_rd_data_i (lut_rd_data_i),
        .match_valid_o (match_valid_o),
        .match_ready_i (match_ready_i),
        .match_pos_o   (match_pos_o),
        .match_size_o  (match_size_o),
        .match_mask_o  (match_mask_o),
        .cnt_clr_i     (cnt_clr_i),
        .hit_cnt_o     (hit_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // LUT word with value v in the HASHES_CNT-bit slot of string size `size`.
    function automatic logic [LUT_W-1:0] lut_bits(input int size, input logic [5:0] v);
        logic [LUT_W-1:0] w;
        w = '0;
        w[(size-8)*6 +: 6] = v;
        return w;
    endfunction

    initial begin
        rst_i = 1'b1;
        config_i = 1'b0;
        hash_valid_i = 1'b0;
        hash_pos_i = '0;
        lut_rd_data_i = '0;
        match_ready_i = 1'b0;
        cnt_clr_i = 1'b0;

        // ---- reset state ----
        #3;
        chk("rst_valid", match_valid_o, 0);
        chk("rst_pos", match_pos_o, 0);
        chk("rst_hit", hit_cnt_o, 0);
        chk("rst_drop", drop_cnt_o, 0);
        step();
        step();
        rst_i = 1'b0;
        step();
        chk("post_rst_valid", match_valid_o, 0);

        // ---- single hit at size 12 ----
        hash_valid_i = 1'b1; hash_pos_i = 16'h0010;
        step();
        hash_valid_i = 1'b0; lut_rd_data_i = lut_bits(12, 6'h3F);
        step();
        lut_rd_data_i = '0;
        chk("single_valid", match_valid_o, 1);
        chk("single_pos", match_pos_o, 32'h0010);
        chk("single_size", match_size_o, 12);
        chk("single_mask", match_mask_o, 32'h0010);
        chk("single_hit", hit_cnt_o, 1);
        chk("single_drop", drop_cnt_o, 0);
        step();
        chk("single_held", match_pos_o, 32'h0010);
        match_ready_i = 1'b1;
        step();
        match_ready_i = 1'b0;
        chk("single_popped", match_valid_o, 0);

        // ---- partial hashes on aligned cycle, full vector on non-aligned ----
        hash_valid_i = 1'b1; hash_pos_i = 16'h0020;
        step();
        hash_valid_i = 1'b0; lut_rd_data_i = lut_bits(12, 6'h3E);
        step();
        lut_rd_data_i = lut_bits(12, 6'h3F);
        step();
        lut_rd_data_i = '0;
        step();
        chk("partial_valid", match_valid_o, 0);
        chk("partial_hit", hit_cnt_o, 1);

        // ---- sizes 8 and 20 together ----
        hash_valid_i = 1'b1; hash_pos_i = 16'h0100;
        step();
        hash_valid_i = 1'b0; lut_rd_data_i = lut_bits(8, 6'h3F) | lut_bits(20, 6'h3F);
        step();
        lut_rd_data_i = '0;
        chk("multi_valid", match_valid_o, 1);
        chk("multi_pos", match_pos_o, 32'h0100);
        chk("multi_size", match_size_o, 20);
        chk("multi_mask", match_mask_o, 32'h1001);
        chk("multi_hit", hit_cnt_o, 2);
        match_ready_i = 1'b1;
        step();
        match_ready_i = 1'b0;
        chk("multi_popped", match_valid_o, 0);

        // ---- backpressure: 17 hits into a 16-entry FIFO ----
        lut_rd_data_i = lut_bits(10, 6'h3F);
        for (int i = 0; i < 18; i++) begin
            hash_valid_i = (i < 17);
            hash_pos_i = 16'(i);
            step();
        end
        hash_valid_i = 1'b0; lut_rd_data_i = '0;
        chk("bp_valid", match_valid_o, 1);
        chk("bp_head", match_pos_o, 0);
        chk("bp_size", match_size_o, 10);
        chk("bp_hit", hit_cnt_o, 19);
        chk("bp_drop", drop_cnt_o, 1);

        // ---- full with simultaneous push and pop ----
        hash_valid_i = 1'b1; hash_pos_i = 16'h0055;
        step();
        hash_valid_i = 1'b0; lut_rd_data_i = lut_bits(14, 6'h3F); match_ready_i = 1'b1;
        step();
        lut_rd_data_i = '0;
        chk("fullpop_drop", drop_cnt_o, 1);
        chk("fullpop_hit", hit_cnt_o, 20);
        for (int j = 1; j < 16; j++) begin
            chk("drain_valid", match_valid_o, 1);
            chk("drain_pos", match_pos_o, 32'(j));
            step();
        end
        chk("drain_last_pos", match_pos_o, 32'h0055);
        chk("drain_last_size", match_size_o, 14);
        step();
        chk("drain_empty", match_valid_o, 0);
        match_ready_i = 1'b0;

        // ---- config flush: 3 queued, 1 in flight ----
        lut_rd_data_i = lut_bits(16, 6'h3F);
        for (int i = 0; i < 4; i++) begin
            hash_valid_i = 1'b1;
            hash_pos_i = 16'h0200 + 16'(i);
            step();
        end
        hash_valid_i = 1'b0;
        chk("cfg_pre_valid", match_valid_o, 1);
        chk("cfg_pre_hit", hit_cnt_o, 23);
        config_i = 1'b1;
        step();
        chk("cfg_flushed", match_valid_o, 0);
        step();
        config_i = 1'b0;
        step();
        step();
        lut_rd_data_i = '0;
        chk("cfg_no_emit", match_valid_o, 0);
        chk("cfg_hit", hit_cnt_o, 23);
        chk("cfg_drop", drop_cnt_o, 1);

        // ---- counter clear ----
        cnt_clr_i = 1'b1;
        step();
        cnt_clr_i = 1'b0;
        chk("clr_hit", hit_cnt_o, 0);
        chk("clr_drop", drop_cnt_o, 0);

        // ---- asynchronous reset mid-operation ----
        hash_valid_i = 1'b1; hash_pos_i = 16'h0300;
        step();
        hash_pos_i = 16'h0301; lut_rd_data_i = lut_bits(9, 6'h3F);
        step();
        hash_valid_i = 1'b0; lut_rd_data_i = '0;
        chk("pre_rst_valid", match_valid_o, 1);
        chk("pre_rst_hit", hit_cnt_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_valid", match_valid_o, 0);
        chk("async_rst_pos", match_pos_o, 0);
        chk("async_rst_hit", hit_cnt_o, 0);
        lut_rd_data_i = lut_bits(9, 6'h3F);
        step();
        rst_i = 1'b0;
        step();
        step();
        lut_rd_data_i = '0;
        chk("after_rst_valid", match_valid_o, 0);
        chk("after_rst_hit", hit_cnt_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bloom_match_collector.md
Name: bloom_match_collector

Overview:
- Downstream stage of the hash LUT. Aligns each lookup with the LUT read data that comes back for it.
- For every string size, ANDs the HASHES_CNT membership bits to decide a Bloom hit.
- Selects the longest matching size and queues match records in a FIFO for a ready/valid consumer. Keeps saturating hit and drop counters.

Parameters:
- MAX_STR_SIZE, 20, longest string size checked
- MIN_STR_SIZE, 8, shortest string size checked
- HASHES_CNT, 6, hashes per string size
- LUT_RD_LATENCY, 1, cycles from hash_valid_i to valid lut_rd_data_i (>=1)
- POS_W, 16, stream byte-position width
- FIFO_DEPTH, 16, match FIFO entries (power of two, >=2)
- CNT_W, 32, statistics counter width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- config_i  in  1  LUT configuration in progress; suppresses detection and flushes the block
- hash_valid_i  in  1  hash addresses for a new position were presented to the LUT this cycle
- hash_pos_i  in  POS_W  stream position of the last byte of the window
- lut_rd_data_i  in  STR_SIZES_CNT*HASHES_CNT  LUT read bits, [MAX_STR_SIZE:MIN_STR_SIZE][HASHES_CNT-1:0]
- match_valid_o  out  1  FIFO head valid
- match_ready_i  in  1  consumer accepts the head
- match_pos_o  out  POS_W  head position
- match_size_o  out  $clog2(MAX_STR_SIZE+1)  longest matching size at the head
- match_mask_o  out  STR_SIZES_CNT  all matching sizes at the head; bit i = size MIN_STR_SIZE+i
- cnt_clr_i  in  1  synchronous clear of both counters
- hit_cnt_o  out  CNT_W  positions with at least one size hit
- drop_cnt_o  out  CNT_W  hits lost because the FIFO was full

Behaviour:
- STR_SIZES_CNT = MAX_STR_SIZE-MIN_STR_SIZE+1.
- Reset: all outputs 0. Delay line, FIFO pointers and counters cleared.
- Delay line:
  - {valid, pos} is shifted through LUT_RD_LATENCY register stages.
  - The stage-out valid is the "aligned" cycle; lut_rd_data_i is sampled in that cycle.
  - lut_rd_data_i is ignored in any cycle that is not aligned.
- Hit detection (combinational on the aligned cycle):
  - mask[i] = AND over h of lut_rd_data_i[MIN_STR_SIZE+i][h].
  - hit = |mask.
  - size = highest set index + MIN_STR_SIZE.
- Push: aligned cycle, hit=1 and config_i=0.
  - Accepted if the FIFO is not full, or if a pop happens in the same cycle (full with simultaneous pop: push accepted, occupancy stays FIFO_DEPTH).
  - Rejected otherwise: drop_cnt_o += 1.
- hit_cnt_o += 1 on every push attempt, whether accepted or dropped.
- Counters saturate at all-ones. cnt_clr_i has priority over an increment in the same cycle.
- Latency: a record pushed in cycle t (aligned cycle = hash_valid_i cycle + LUT_RD_LATENCY) is visible on match_* in t+1.
- FIFO:
  - Show-ahead: match_valid_o = !empty; head fields are stable while match_valid_o=1 and match_ready_i=0.
  - Pop when match_valid_o && match_ready_i.
  - Strict arrival order. Pointers wrap modulo FIFO_DEPTH; an extra MSB distinguishes full from empty.
- Empty FIFO with simultaneous push: the record appears the next cycle. No bypass.
- config_i=1, every cycle it is high:
  - delay-line valids cleared, so in-flight lookups are discarded;
  - FIFO flushed (pointers reset, match_valid_o=0 the next cycle);
  - no pushes and no counter increments;
  - match_ready_i ignored.
  - After config_i falls, only hash_valid_i pulses issued while config_i=0 can produce records.
- Asynchronous reset mid-operation: immediate return to the reset state. No record is emitted from pre-reset lookups.

Decomposition:
- bloom_filter_pkg additions:
  - match_rec_t struct {pos, size, mask}, parameterised through package localparams;
  - STR_SIZE_W = $clog2(MAX_STR_SIZE+1);
  - function longest_size(mask) returning the highest set index + MIN_STR_SIZE.
- Sub-module: match_fifo, a show-ahead synchronous FIFO with ports push/pop/data/full/empty and a flush input, instantiated with match_rec_t data.
- The top level holds the delay line, hit logic and counters.

Test Plan:
- Reset: assert rst_i asynchronously mid-clock -> all outputs 0 immediately, match_valid_o=0 after release.
- Single hit: hash_valid_i=1, pos=0x0010 at t; at t+1 lut_rd_data_i[12]=6'h3F, others 0 -> t+2: match_valid_o=1, pos 0x0010, size 12, mask 13'h0010, hit_cnt_o=1.
- Partial hashes: lut_rd_data_i[12]=6'h3E at the aligned cycle -> no record, counters unchanged. An all-ones vector in a non-aligned cycle is also ignored.
- Multi-size: sizes 8 and 20 all-ones at pos=0x0100 -> size 20, mask 13'h1001.
- Backpressure: match_ready_i=0, 17 consecutive hits pos 0..16 -> 16 records, drop_cnt_o=1, hit_cnt_o=17. Then ready=1 -> pops pos 0..15 in order.
- Full with pop: FIFO full, a push and a pop in the same cycle -> push accepted, drop_cnt_o unchanged.
- Config flush: 3 records queued, 1 lookup in flight, then config_i=1 for 2 cycles -> match_valid_o=0, the in-flight lookup never emits, counters unchanged.
